bht_counter_table: RTL and testbench



---
 rtl/ariane_pkg.sv | 55 +++++
 rtl/riscv.sv | 6 +
 rtl/bht_sweep_ctrl.sv | 47 ++++
 rtl/bht_counter_table.sv | 86 ++++++++
 tb/tb_bht_counter_table.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg
// Shared frontend/execute types: control-flow classification, the resolved-branch
// record, and the BHT row format with its counter-update helper.
//   cf_t             : control-flow type of a resolved instruction.
//   bp_resolve_t     : resolution record from the execute stage.
//   bht_entry_t      : one BHT row {valid, saturation_counter[1:0]}.
//   bht_next_counter : updated row for a taken / not-taken outcome.
package ariane_pkg;

   typedef enum logic [2:0] {
      NoCF,
      Branch,
      Jump,
      JumpR,
      Return
   } cf_t;

   typedef struct packed {
      logic                   valid;
      logic [riscv::VLEN-1:0] pc;
      logic [riscv::VLEN-1:0] target_address;
      logic                   is_mispredict;
      logic                   is_taken;
      cf_t                    cf_type;
   } bp_resolve_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] saturation_counter;
   } bht_entry_t;

   localparam logic [1:0] BHT_STRONG_NT = 2'b00;
   localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
   localparam logic [1:0] BHT_WEAK_T    = 2'b10;
   localparam logic [1:0] BHT_STRONG_T  = 2'b11;

   // An untrained row jumps straight to the weak state of the observed
   // direction; a trained row moves one step and saturates at either end.
   function automatic bht_entry_t bht_next_counter(input bht_entry_t e, input logic taken);
      bht_entry_t n;
      n = e;
      if (!e.valid) begin
         n.valid              = 1'b1;
         n.saturation_counter = taken ? BHT_WEAK_T : BHT_WEAK_NT;
      end else if (taken) begin
         if (e.saturation_counter != BHT_STRONG_T)
            n.saturation_counter = e.saturation_counter + 2'd1;
      end else begin
         if (e.saturation_counter != BHT_STRONG_NT)
            n.saturation_counter = e.saturation_counter - 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/riscv.sv
// riscv
// Core-wide ISA sizing constants used by the branch-prediction slice.
//   VLEN : virtual address width in bits.
package riscv;
   localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_sweep_ctrl.sv
// bht_sweep_ctrl
// SWEEP/RUN controller that clears the BHT one row per cycle after reset or flush.
//   i_clk        : clock
//   i_rst        : synchronous active-high reset (wins over i_flush)
//   i_flush      : restart the sweep at row 0 from any state
//   o_ready      : table is live (RUN)
//   o_sweep_we   : clear the row at o_sweep_idx on this edge
//   o_sweep_idx  : row being cleared
module bht_sweep_ctrl #(
   parameter int unsigned NR_ENTRIES = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   output logic                          o_ready,
   output logic                          o_sweep_we,
   output logic [$clog2(NR_ENTRIES)-1:0] o_sweep_idx
);
   localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES);
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NR_ENTRIES - 1);

   typedef enum logic {SWEEP, RUN} sweep_state_e;

   sweep_state_e          r_state;
   logic [INDEX_BITS-1:0] r_idx;
   logic                  r_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_state <= SWEEP;
         r_idx   <= '0;
         r_ready <= 1'b0;
      end else if (r_state == SWEEP) begin
         r_idx <= r_idx + INDEX_BITS'(1);
         // The edge that clears the last row also enters RUN.
         if (r_idx == LAST_IDX) begin
            r_state <= RUN;
            r_ready <= 1'b1;
         end
      end
   end

   assign o_ready     = r_ready;
   assign o_sweep_we  = (r_state == SWEEP);
   assign o_sweep_idx = r_idx;

endmodule

// File: rtl/bht_counter_table.sv
// bht_counter_table
// Branch history table of 2-bit saturating counters, trained by resolved
// branches and read combinationally by the frontend.
// Optional feature macro: BHT_BYPASS_EN -- a qualified update to the row being
// looked up in the same cycle is forwarded to the lookup outputs.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : restart the clear sweep; drops a concurrent update
//   debug_mode_i       : suppresses updates
//   vpc_i              : fetch PC to predict
//   resolved_branch_i  : execute-stage resolution record
//   bht_valid_o        : prediction backed by a trained row
//   bht_taken_o        : predicted direction
//   ready_o            : sweep finished, table live
module bht_counter_table
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = 1024,
   parameter int unsigned PC_OFFSET  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   debug_mode_i,
   input  logic [riscv::VLEN-1:0] vpc_i,
   input  bp_resolve_t            resolved_branch_i,
   output logic                   bht_valid_o,
   output logic                   bht_taken_o,
   output logic                   ready_o
);
   localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES);

   bht_entry_t            r_mem [NR_ENTRIES];

   logic                  w_ready;
   logic                  w_sweep_we;
   logic [INDEX_BITS-1:0] w_sweep_idx;
   logic [INDEX_BITS-1:0] w_ridx;
   logic [INDEX_BITS-1:0] w_uidx;
   logic                  w_upd;
   bht_entry_t            w_upd_entry;
   bht_entry_t            w_row;
   logic                  w_unused;

   bht_sweep_ctrl #(.NR_ENTRIES(NR_ENTRIES)) u_sweep (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_flush     (flush_i),
      .o_ready     (w_ready),
      .o_sweep_we  (w_sweep_we),
      .o_sweep_idx (w_sweep_idx)
   );

   assign w_ridx = vpc_i[PC_OFFSET +: INDEX_BITS];
   assign w_uidx = resolved_branch_i.pc[PC_OFFSET +: INDEX_BITS];

   // Only conditional branches train; w_ready already excludes the whole
   // sweep, including its final cycle.
   assign w_upd = w_ready & resolved_branch_i.valid & (resolved_branch_i.cf_type == Branch)
                & ~debug_mode_i & ~flush_i;

   assign w_upd_entry = bht_next_counter(r_mem[w_uidx], resolved_branch_i.is_taken);

   // Single write port: sweep and update are mutually exclusive by state.
   always_ff @(posedge clk_i) begin
      if (w_sweep_we)
         r_mem[w_sweep_idx] <= '{valid: 1'b0, saturation_counter: BHT_WEAK_NT};
      else if (w_upd)
         r_mem[w_uidx] <= w_upd_entry;
   end

   always_comb begin
      w_row = r_mem[w_ridx];
`ifdef BHT_BYPASS_EN
      if (w_upd && (w_uidx == w_ridx))
         w_row = w_upd_entry;
`endif
   end

   assign bht_valid_o = w_ready & w_row.valid;
   assign bht_taken_o = w_ready & w_row.valid & w_row.saturation_counter[1];
   assign ready_o     = w_ready;

   // Address bits outside the index and unused record fields.
   assign w_unused = ^{vpc_i, resolved_branch_i};

endmodule

// File: tb/tb_bht_counter_table.sv
module tb_bht_counter_table;
   import ariane_pkg::*;

   localparam int NR = 1024;

   logic        clk = 1'b0;
   logic        rst, flush, dbg;
   logic [63:0] vpc;
   bp_resolve_t rb;
   logic        bv, bt, rdy;

   always #5 clk = ~clk;

   bht_counter_table dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .flush_i           (flush),
      .debug_mode_i      (dbg),
      .vpc_i             (vpc),
      .resolved_branch_i (rb),
      .bht_valid_o       (bv),
      .bht_taken_o       (bt),
      .ready_o           (rdy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: trained flag and counter value 0..3 per row, plus the
   // number of sweep cycles completed since the last reset/flush.
   int m_valid [NR];
   int m_cnt   [NR];
   bit m_ready = 1'b0;
   int m_count = 0;

   function automatic int idx_of(input logic [63:0] a);
      return int'(a[10:1]);
   endfunction

   function automatic void mnext(input int v, input int c, input bit t, output int nv, output int nc);
      nv = 1;
      if (v == 0)  nc = t ? 2 : 1;
      else if (t)  nc = (c == 3) ? 3 : c + 1;
      else         nc = (c == 0) ? 0 : c - 1;
   endfunction

   function automatic bit qual();
      return m_ready && rb.valid && (rb.cf_type == Branch) && !dbg && !flush;
   endfunction

   task automatic set_in(input bit r, input bit f, input bit d, input logic [63:0] lpc,
                         input bit uv, input logic [63:0] upc, input bit tk, input cf_t cf);
      rst   = r;
      flush = f;
      dbg   = d;
      vpc   = lpc;
      rb    = '0;
      rb.valid    = uv;
      rb.pc       = upc;
      rb.is_taken = tk;
      rb.cf_type  = cf;
   endtask

   // Apply the current inputs to the model, then advance one clock.
   task automatic tick();
      int nv, nc, i;
      if (rst || flush) begin
         m_ready = 1'b0;
         m_count = 0;
         for (int k = 0; k < NR; k++) begin m_valid[k] = 0; m_cnt[k] = 1; end
      end else if (!m_ready) begin
         m_count++;
         if (m_count == NR) m_ready = 1'b1;
      end else if (qual()) begin
         i = idx_of(rb.pc);
         mnext(m_valid[i], m_cnt[i], rb.is_taken, nv, nc);
         m_valid[i] = nv;
         m_cnt[i]   = nc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: {ready,valid,taken} got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string nm);
      int  v, c, i, nv, nc;
      bit  ev, et;
      i = idx_of(vpc);
      v = m_valid[i];
      c = m_cnt[i];
`ifdef BHT_BYPASS_EN
      if (qual() && idx_of(rb.pc) == i) begin
         mnext(v, c, rb.is_taken, nv, nc);
         v = nv;
         c = nc;
      end
`endif
      ev = m_ready && (v != 0);
      et = ev && (c >= 2);
      chk3(nm, {rdy, bv, bt}, {m_ready, ev, et});
   endtask

   // Idle/sweep watch: updates to lpc are offered during the sweep (they must
   // be dropped), ready must rise only at cycle NR.
   task automatic sweep_run(input int ncyc, input logic [63:0] lpc);
      for (int k = 0; k < ncyc; k++) begin
         set_in(0, 0, 0, lpc, k < NR, lpc, 1'b1, Branch);
         #2;
         chk3($sformatf("sweep k=%0d", k), {rdy, bv, bt}, {k >= NR, 1'b0, 1'b0});
         tick();
      end
   endtask

   typedef struct {
      string       nm;
      logic [63:0] upc;
      cf_t         cf;
      bit          tk;
      bit          d;
      logic [63:0] lpc;
      bit          ev;
      bit          et;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input logic [63:0] upc, input cf_t cf, input bit tk,
                      input bit d, input logic [63:0] lpc, input bit ev, input bit et);
      vec_t e;
      e.nm = nm; e.upc = upc; e.cf = cf; e.tk = tk; e.d = d; e.lpc = lpc; e.ev = ev; e.et = et;
      tbl.push_back(e);
   endtask

   initial begin
      logic [2:0] exp_byp;
      logic [63:0] pa, pb;

      add("t10 first",   64'h80000010, Branch, 1, 0, 64'h80000010, 1, 1);
      add("t10 sat11",   64'h80000010, Branch, 1, 0, 64'h80000010, 1, 1);
      add("t10 nt 10",   64'h80000010, Branch, 0, 0, 64'h80000010, 1, 1);
      add("t10 nt 01",   64'h80000010, Branch, 0, 0, 64'h80000010, 1, 0);
      add("t20 nt 01",   64'h80000020, Branch, 0, 0, 64'h80000020, 1, 0);
      add("t20 nt 00",   64'h80000020, Branch, 0, 0, 64'h80000020, 1, 0);
      add("t20 nt 00b",  64'h80000020, Branch, 0, 0, 64'h80000020, 1, 0);
      add("t20 nt 00c",  64'h80000020, Branch, 0, 0, 64'h80000020, 1, 0);
      add("t20 t 01",    64'h80000020, Branch, 1, 0, 64'h80000020, 1, 0);
      add("t20 t 10",    64'h80000020, Branch, 1, 0, 64'h80000020, 1, 1);
      add("t30 jumpr",   64'h80000030, JumpR,  1, 0, 64'h80000030, 0, 0);
      add("t30 return",  64'h80000030, Return, 1, 0, 64'h80000030, 0, 0);
      add("t30 debug",   64'h80000030, Branch, 1, 1, 64'h80000030, 0, 0);
      add("alias 800",   64'h80000000, Branch, 1, 0, 64'h80000800, 1, 1);

      // Reset, then the full sweep: ready low for cycles 0..1023.
      set_in(1, 0, 0, 64'h0, 0, 64'h0, 0, NoCF);
      tick();
      sweep_run(NR + 1, 64'h80000000);

      // Every row reads untrained after the sweep.
      for (int i = 0; i < NR; i++) begin
         set_in(0, 0, 0, 64'h80000000 | (64'(i) << 1), 0, 64'h0, 0, NoCF);
         #2;
         chk3($sformatf("clear idx %0d", i), {rdy, bv, bt}, 3'b100);
         tick();
      end

      // Directed training table: update one cycle, look up the next.
      foreach (tbl[j]) begin
         set_in(0, 0, tbl[j].d, 64'h90000400, 1, tbl[j].upc, tbl[j].tk, tbl[j].cf);
         #2;
         chk_model({tbl[j].nm, " upd"});
         tick();
         set_in(0, 0, 0, tbl[j].lpc, 0, 64'h0, 0, NoCF);
         #2;
         chk3(tbl[j].nm, {rdy, bv, bt}, {1'b1, tbl[j].ev, tbl[j].et});
         tick();
      end

      // Same-cycle update and lookup of an untrained row.
`ifdef BHT_BYPASS_EN
      exp_byp = 3'b111;
`else
      exp_byp = 3'b100;
`endif
      set_in(0, 0, 0, 64'h80000100, 1, 64'h80000100, 1, Branch);
      #2;
      chk3("bypass same cycle", {rdy, bv, bt}, exp_byp);
      tick();
      set_in(0, 0, 0, 64'h80000100, 0, 64'h0, 0, NoCF);
      #2;
      chk3("bypass next cycle", {rdy, bv, bt}, 3'b111);
      tick();

      // Flush with a concurrent update: lookup shows the untouched row (01).
      set_in(0, 1, 0, 64'h80000010, 1, 64'h80000010, 1, Branch);
      #2;
      chk3("flush cycle", {rdy, bv, bt}, 3'b110);
      tick();
      sweep_run(NR + 1, 64'h80000010);

      // Flush again at sweep index 500: the sweep restarts from 0.
      set_in(0, 1, 0, 64'h0, 0, 64'h0, 0, NoCF);
      tick();
      sweep_run(500, 64'h80000010);
      set_in(0, 1, 0, 64'h80000010, 1, 64'h80000010, 1, Branch);
      #2;
      chk3("reflush at 500", {rdy, bv, bt}, 3'b000);
      tick();
      sweep_run(NR + 1, 64'h80000010);

      // Reset wins over flush.
      set_in(1, 1, 0, 64'h0, 0, 64'h0, 0, NoCF);
      tick();
      sweep_run(NR + 1, 64'h80000040);

      // Randomized traffic against the model over a small set of aliasing rows.
      for (int n = 0; n < 3000; n++) begin
         pa = 64'h80000000 + (64'($urandom_range(0, 15)) << 1) + (64'($urandom_range(0, 1)) << 11);
         pb = 64'h80000000 + (64'($urandom_range(0, 15)) << 1) + (64'($urandom_range(0, 1)) << 11);
         set_in($urandom_range(0, 999) == 0, $urandom_range(0, 1499) == 0,
                $urandom_range(0, 7) == 0, pa, $urandom_range(0, 3) != 0, pb,
                1'($urandom_range(0, 1)), cf_t'($urandom_range(0, 4)));
         #2;
         chk_model($sformatf("rand %0d", n));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
